// File: rtl/serial_addsub.sv
// Bit-serial N-bit adder/subtractor: captures operands on start, adds one bit per
// clock LSB first, then presents S/Co and a Valid flag for unsigned or signed mode.
module serial_addsub #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [N-1:0] A_i,
  input  logic [N-1:0] B_i,
  input  logic         Sub_i,
  input  logic         RC_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] S_o,
  output logic         Co_o,
  output logic         Valid_o
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   r_q, r_d;
  logic           carry_q, carry_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sub_q, sub_d;
  logic           rc_q, rc_d;
  logic           aMsb_q, aMsb_d;
  logic           bMsb_q, bMsb_d;
  logic [N-1:0]   s_q, s_d;
  logic           co_q, co_d;
  logic           valid_q, valid_d;

  logic sumBit;
  logic carryNext;
  logic sMsb;
  logic validCalc;

  assign sumBit    = a_q[0] ^ b_q[0] ^ carry_q;
  assign carryNext = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign sMsb      = r_q[N-1];

  // Overflow check uses the MSBs of the operands as originally presented, not the inverted B.
  always_comb begin
    validCalc = 1'b0;
    case ({rc_q, sub_q})
      2'b00:   validCalc = ~carry_q;
      2'b01:   validCalc = carry_q;
      2'b10:   validCalc = ~((aMsb_q == bMsb_q) && (sMsb != aMsb_q));
      default: validCalc = ~((aMsb_q != bMsb_q) && (sMsb != aMsb_q));
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    rc_d    = rc_q;
    aMsb_d  = aMsb_q;
    bMsb_d  = bMsb_q;
    s_d     = s_q;
    co_d    = co_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = A_i;
          b_d     = B_i ^ {N{Sub_i}};
          carry_d = Sub_i;
          sub_d   = Sub_i;
          rc_d    = RC_i;
          aMsb_d  = A_i[N-1];
          bMsb_d  = B_i[N-1];
          r_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // The extra RUN cycle after the last bit is where the finished result is committed.
        if (cnt_q == CW'(N)) begin
          s_d     = r_q;
          co_d    = carry_q;
          valid_d = validCalc;
          state_d = DONE;
        end else begin
          r_d     = {sumBit, r_q[N-1:1]};
          carry_d = carryNext;
          a_d     = a_q >> 1;
          b_d     = b_q >> 1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sub_q   <= 1'b0;
      rc_q    <= 1'b0;
      aMsb_q  <= 1'b0;
      bMsb_q  <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      rc_q    <= rc_d;
      aMsb_q  <= aMsb_d;
      bMsb_q  <= bMsb_d;
      s_q     <= s_d;
      co_q    <= co_d;
      valid_q <= valid_d;
    end
  end

  assign busy_o  = (state_q == RUN) || (state_q == DONE);
  assign done_o  = (state_q == DONE);
  assign S_o     = s_q;
  assign Co_o    = co_q;
  assign Valid_o = valid_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (N=4): directed spec vectors, start blocking,
// back-to-back operation, mid-run reset and randomized ops against an arithmetic model.
module tb_serial_addsub;

  localparam int N = 4;
  localparam int MOD = 1 << N;

  logic         clk;
  logic         reset;
  logic         start;
  logic [N-1:0] aIn;
  logic [N-1:0] bIn;
  logic         subIn;
  logic         rcIn;
  logic         busy;
  logic         done;
  logic [N-1:0] sOut;
  logic         coOut;
  logic         validOut;

  int nAsserts = 0;
  int nFails   = 0;

  serial_addsub #(.N(N)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .start_i (start),
    .A_i     (aIn),
    .B_i     (bIn),
    .Sub_i   (subIn),
    .RC_i    (rcIn),
    .busy_o  (busy),
    .done_o  (done),
    .S_o     (sOut),
    .Co_o    (coOut),
    .Valid_o (validOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference: plain integer arithmetic, carry as unsigned overflow / no-borrow,
  // validity as range membership of the true mathematical result.
  task automatic refModel(input int a, input int b, input bit sub, input bit rc,
                          output logic [N-1:0] s, output logic co, output logic valid);
    int full;
    int sa;
    int sb;
    int r;
    full  = sub ? (a + MOD - b) : (a + b);
    s     = N'(full % MOD);
    co    = (full >= MOD);
    sa    = (a >= MOD / 2) ? a - MOD : a;
    sb    = (b >= MOD / 2) ? b - MOD : b;
    r     = sub ? sa - sb : sa + sb;
    if (rc) valid = (r >= -(MOD / 2)) && (r < MOD / 2);
    else    valid = sub ? (a >= b) : (a + b < MOD);
  endtask

  task automatic applyStimulus(input int a, input int b, input bit sub, input bit rc);
    @(negedge clk);
    aIn   = N'(a);
    bIn   = N'(b);
    subIn = sub;
    rcIn  = rc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    aIn   = N'($urandom_range(0, MOD - 1));
    bIn   = N'($urandom_range(0, MOD - 1));
    subIn = 1'($urandom_range(0, 1));
    rcIn  = 1'($urandom_range(0, 1));
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (done !== 1'b1 && cycles < 20);
  endtask

  task automatic runOp(input string tag, input int a, input int b, input bit sub, input bit rc);
    logic [N-1:0] expS;
    logic         expCo;
    logic         expValid;
    int           cycles;
    refModel(a, b, sub, rc, expS, expCo, expValid);
    applyStimulus(a, b, sub, rc);
    waitDone(cycles);
    checkOutput({tag, " latency"}, cycles, N + 1);
    checkOutput({tag, " busy"}, busy, 1);
    checkOutput({tag, " S"}, sOut, expS);
    checkOutput({tag, " Co"}, coOut, expCo);
    checkOutput({tag, " Valid"}, validOut, expValid);
    @(negedge clk);
    checkOutput({tag, " done drop"}, done, 0);
    checkOutput({tag, " S hold"}, sOut, expS);
  endtask

  initial begin
    logic [N-1:0] expS;
    logic         expCo;
    logic         expValid;
    int           cycles;
    int           doneCount;

    reset = 1'b1;
    start = 1'b0;
    aIn   = '0;
    bIn   = '0;
    subIn = 1'b0;
    rcIn  = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset S", sOut, 0);
    checkOutput("reset Co", coOut, 0);
    checkOutput("reset Valid", validOut, 0);
    reset = 1'b0;

    runOp("u add 3+4", 3, 4, 0, 0);
    checkOutput("u add 3+4 literal S", sOut, 7);
    runOp("u add 12+5", 12, 5, 0, 0);
    runOp("u sub 3-5", 3, 5, 1, 0);
    runOp("u sub 5-3", 5, 3, 1, 0);
    runOp("s add 5+4", 5, 4, 0, 1);
    runOp("s add 8+15", 8, 15, 0, 1);
    runOp("s sub 4-11", 4, 11, 1, 1);
    runOp("s sub 2-3", 2, 3, 1, 1);
    checkOutput("s sub 2-3 literal S", sOut, 15);

    // Start pulses with a different A while busy must not disturb the running op.
    refModel(3, 4, 0, 0, expS, expCo, expValid);
    applyStimulus(3, 4, 0, 0);
    doneCount = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) doneCount++;
      aIn   = 4'd9;
      start = (i <= 3);
    end
    start = 1'b0;
    checkOutput("ignored start done count", doneCount, 1);
    checkOutput("ignored start S", sOut, expS);
    checkOutput("ignored start busy", busy, 0);

    // Start held high: a second op starts from IDLE with whatever inputs are present then.
    @(negedge clk);
    aIn   = 4'd1;
    bIn   = 4'd2;
    subIn = 1'b0;
    rcIn  = 1'b0;
    start = 1'b1;
    waitDone(cycles);
    checkOutput("b2b first latency", cycles, N + 2);
    checkOutput("b2b first S", sOut, 3);
    aIn   = 4'd5;
    bIn   = 4'd6;
    refModel(5, 6, 0, 0, expS, expCo, expValid);
    waitDone(cycles);
    start = 1'b0;
    checkOutput("b2b second latency", cycles, N + 3);
    checkOutput("b2b second S", sOut, expS);
    checkOutput("b2b second Valid", validOut, expValid);
    repeat (3) @(negedge clk);

    // Reset in the middle of RUN clears everything; the next op must be clean.
    applyStimulus(12, 5, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrun reset busy", busy, 0);
    checkOutput("midrun reset done", done, 0);
    checkOutput("midrun reset S", sOut, 0);
    checkOutput("midrun reset Co", coOut, 0);
    checkOutput("midrun reset Valid", validOut, 0);
    reset = 1'b0;
    runOp("after reset 3+4", 3, 4, 0, 0);
    checkOutput("after reset literal S", sOut, 7);

    for (int i = 0; i < 24; i++) begin
      runOp($sformatf("rand %0d", i), int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
